code_loader: RTL
================

CODE_LOADER -- requirements
Module: code_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per UART bit (min 4).
REQ-002 SHALL have parameter ADDR_W, default 8, meaning code memory address width.
REQ-003 SHALL have parameter WORD_W, default 16, meaning instruction width; fixed at 16 (two bytes).
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 rx  input  1  UART serial in, 8N1, idle high, asynchronous to clk.
REQ-007 code_w_en  output  1  code memory write strobe, one-cycle pulse.
REQ-008 code_addr_in  output  ADDR_W  code memory write address.
REQ-009 code_in  output  WORD_W  code memory write data.
REQ-010 run  output  1  high once the program is fully loaded; drives datapath run.
REQ-011 busy  output  1  high while a load is in progress (count byte received, not yet DONE).
REQ-012 err  output  1  sticky framing-error flag.

Function
REQ-013 SHALL resynchronise rx through two flops before any use.
REQ-014 SHALL detect a start bit on a synchronised falling edge and sample it at CLKS_PER_BIT/2; rx high there is a false start and returns to idle with no byte.
REQ-015 SHALL sample data bits LSB first at bit centres, then the stop bit; stop=1 gives one-cycle byte_valid, stop=0 gives one-cycle frame_err, no byte.
REQ-016 Load protocol: byte 0 = word count N (0..255, clipped to 2^ADDR_W); then N words, high byte first, low byte second.
REQ-017 FSM states: IDLE, HI, LO, WRITE, DONE, ERROR.
REQ-018 IDLE: on byte, N := byte, addr := 0; N=0 -> DONE, else -> HI.
REQ-019 HI: on byte, latch high byte -> LO.
REQ-020 LO: on byte, latch low byte -> WRITE.
REQ-021 WRITE (one cycle): code_w_en=1, code_addr_in=addr, code_in={hi,lo}; addr+1; -> DONE if this was word N-1, else HI.
REQ-022 code_w_en SHALL assert exactly one cycle after the low byte's byte_valid; code_addr_in/code_in stable during that cycle.
REQ-023 DONE: run=1 from the cycle after the final WRITE (or after the count byte for N=0); further rx bytes ignored.
REQ-024 frame_err in any state except DONE -> ERROR; ERROR: err=1, run=0, no writes, exits only by reset.
REQ-025 busy=1 in HI, LO, WRITE; 0 otherwise.
REQ-026 Address SHALL never wrap: at most 2^ADDR_W writes per load; addr counter ADDR_W+1 bits wide internally.
REQ-027 code_in and code_addr_in SHALL hold last written values outside WRITE; code_w_en=0 outside WRITE.

Reset
REQ-028 rst low SHALL asynchronously force: state IDLE, code_w_en=0, code_addr_in=0, code_in=0, run=0, busy=0, err=0, UART receiver idle, synchronisers to 1.
REQ-029 Reset mid-load SHALL abandon the load; memory contents already written are not cleared; next byte after release is a count byte.
REQ-030 Reset deassertion SHALL be synchronised to clk before use by the FSM.

Structure
REQ-031 State encoding and the UART frame constants (data bits 8, stop bits 1) SHALL live in the shared constants package.
REQ-032 UART reception SHALL be a sub-module uart_rx (ports clk, rst, rx, byte_out[7:0], byte_valid, frame_err); code_loader holds protocol FSM and counters.
REQ-033 code_loader SHALL sit upstream of datapath, its outputs wired directly to datapath code_w_en, code_addr_in, code_in, run.

Verification (CLKS_PER_BIT=4, ADDR_W=8)
REQ-034 Send 0x02,0x12,0x34,0xAB,0xCD -> writes (0x00,0x1234),(0x01,0xABCD), each one-cycle code_w_en; run=1 one cycle after second write; busy 0 after.
REQ-035 Send 0x00 -> no code_w_en; run=1 one cycle after count byte_valid.
REQ-036 Count 0x01, high byte with stop bit 0 -> err=1, run=0, no write; further valid bytes ignored until reset.
REQ-037 2-cycle low glitch on idle rx -> no byte, FSM stays IDLE.
REQ-038 Count 0x03, one word loaded, rst pulsed low -> all outputs 0 immediately; then 0x01,0xBE,0xEF -> write (0x00,0xBEEF), run=1.
REQ-039 Bytes sent after run=1 -> no code_w_en, run stays 1.

Source files
------------

// File: rtl/code_loader_pkg.sv
// Shared constants for the code loader: FSM encodings and UART frame shape.
package code_loader_pkg;

  localparam int unsigned UartDataBits = 8;
  localparam int unsigned UartStopBits = 1;

  typedef enum logic [2:0] {
    StIdle,
    StHi,
    StLo,
    StWrite,
    StDone,
    StError
  } state_e;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, one-cycle
// byte_valid or frame_err per frame.
module uart_rx
  import code_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW = $clog2(UartDataBits);
  localparam logic [CntW-1:0] HalfM1 = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullM1 = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] LastBit = BitW'(UartDataBits - 1);

  rx_state_e       state_q, state_d;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [BitW-1:0] bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= RxIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RxIdle: begin
        if (rx_prev_q && !rx_sync_q) begin
          state_d = RxStart;
          cnt_d   = '0;
        end
      end
      RxStart: begin
        if (cnt_q == HalfM1) begin
          cnt_d   = '0;
          bit_d   = '0;
          // Line back high at mid start bit: treat as a glitch.
          state_d = rx_sync_q ? RxIdle : RxData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RxData: begin
        if (cnt_q == FullM1) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          if (bit_q == LastBit) state_d = RxStop;
          else                  bit_d   = bit_q + BitW'(1);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RxStop: begin
        if (cnt_q == FullM1) begin
          cnt_d   = '0;
          state_d = RxIdle;
          valid_d = rx_sync_q;
          ferr_d  = !rx_sync_q;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  assign byte_out   = shift_q;
  assign byte_valid = valid_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/code_loader.sv
// Loads a program over UART into code memory: count byte, then N big-endian
// 16-bit words; raises run once the last word is written.
module code_loader
  import code_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned WORD_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              code_w_en,
  output logic [ADDR_W-1:0] code_addr_in,
  output logic [WORD_W-1:0] code_in,
  output logic              run,
  output logic              busy,
  output logic              err
);

  localparam logic [31:0] MaxWords = 32'(1) << ADDR_W;

  logic [1:0]        rst_sync_q;
  logic              rst_int;
  logic [7:0]        rx_byte;
  logic              rx_valid, rx_ferr;
  state_e            state_q, state_d;
  logic [ADDR_W:0]   addr_q, addr_d, n_q, n_d, n_clip;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] code_addr_q, code_addr_d;
  logic [WORD_W-1:0] code_q, code_d;
  logic [31:0]       count_ext;

  // Assert asynchronously, release on a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= 2'b00;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int = rst_sync_q[1];

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_rx (
    .clk       (clk),
    .rst       (rst_int),
    .rx        (rx),
    .byte_out  (rx_byte),
    .byte_valid(rx_valid),
    .frame_err (rx_ferr)
  );

  assign count_ext = 32'(rx_byte);
  assign n_clip    = (count_ext > MaxWords) ? MaxWords[ADDR_W:0] : count_ext[ADDR_W:0];

  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      n_q         <= '0;
      hi_q        <= '0;
      code_addr_q <= '0;
      code_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      n_q         <= n_d;
      hi_q        <= hi_d;
      code_addr_q <= code_addr_d;
      code_q      <= code_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    n_d         = n_q;
    hi_d        = hi_q;
    code_addr_d = code_addr_q;
    code_d      = code_q;
    if (rx_ferr && state_q != StDone) begin
      state_d = StError;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rx_valid) begin
            n_d     = n_clip;
            addr_d  = '0;
            state_d = (n_clip == '0) ? StDone : StHi;
          end
        end
        StHi: begin
          if (rx_valid) begin
            hi_d    = rx_byte;
            state_d = StLo;
          end
        end
        StLo: begin
          // Present address/data on entry to StWrite; they hold afterwards.
          if (rx_valid) begin
            code_addr_d = addr_q[ADDR_W-1:0];
            code_d      = WORD_W'({hi_q, rx_byte});
            state_d     = StWrite;
          end
        end
        StWrite: begin
          addr_d  = addr_q + (ADDR_W + 1)'(1);
          state_d = (addr_q + (ADDR_W + 1)'(1) == n_q) ? StDone : StHi;
        end
        StDone:  state_d = StDone;
        StError: state_d = StError;
        default: state_d = StError;
      endcase
    end
  end

  always_comb begin
    code_w_en = (state_q == StWrite);
    busy      = (state_q == StHi) || (state_q == StLo) || (state_q == StWrite);
    run       = (state_q == StDone);
    err       = (state_q == StError);
  end

  assign code_addr_in = code_addr_q;
  assign code_in      = code_q;

endmodule
